// File: rtl/core_pkg.sv
// Shared constants for the pipeline control slice: stage indices,
// forwarding-select encodings and the hazard-controller state type.
package core_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_LU_STALL = 3'd2,
    ST_EX_WAIT  = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_HALTED   = 3'd5
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand forwarding priority for one ID source register: the youngest
// writing producer (EX, then MEM, then WB) wins; x0 always reads the regfile.
module fwd_select
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [REG_AW-1:0] ex_addr_i,
  input  logic              ex_we_i,
  input  logic [REG_AW-1:0] mem_addr_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic              wb_we_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (src_addr_i != '0) begin
      if (ex_we_i && (ex_addr_i == src_addr_i)) begin
        sel_o = FWD_EX;
      end else if (mem_we_i && (mem_addr_i == src_addr_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_we_i && (wb_addr_i == src_addr_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit: stall/flush per stage, forwarding selects,
// run/drain/halt sequencing. Optional perf counters: PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 5,
  parameter int LOAD_LAT   = 1
`ifdef PIPE_HAZARD_PERF_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [REG_AW-1:0]     id_rs1_addr,
  input  logic                  id_rs1_re,
  input  logic [REG_AW-1:0]     id_rs2_addr,
  input  logic                  id_rs2_re,
  input  logic                  id_branch,
  input  logic                  id_halt,
  input  logic [REG_AW-1:0]     ex_rd_addr,
  input  logic                  ex_rd_we,
  input  logic                  ex_is_load,
  input  logic [REG_AW-1:0]     mem_rd_addr,
  input  logic                  mem_rd_we,
  input  logic [REG_AW-1:0]     wb_rd_addr,
  input  logic                  wb_rd_we,
  input  logic                  ex_busy,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel,
  output logic                  running,
  output logic                  halt,
  output state_t                dbg_state
`ifdef PIPE_HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    perf_stall_cycles,
  output logic [CNT_W-1:0]      perf_flush_count
`endif
);

  localparam int BUB_W   = 3;
  localparam int DRAIN_W = $clog2(NUM_STAGES);

  state_t             state_q, state_d;
  logic [BUB_W-1:0]   bub_cnt_q, bub_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               running_q, halt_q;
  logic               lu_hazard;
  logic [NUM_STAGES-1:0] stall_c, flush_c;

  // A load in EX cannot forward in time to a dependent instruction in ID.
  assign lu_hazard = ex_is_load && ex_rd_we && (ex_rd_addr != '0) &&
                     ((id_rs1_re && (id_rs1_addr == ex_rd_addr)) ||
                      (id_rs2_re && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    state_d     = state_q;
    bub_cnt_d   = bub_cnt_q;
    drain_cnt_d = drain_cnt_q;
    stall_c     = '0;
    flush_c     = '0;
    case (state_q)
      ST_IDLE: begin
        stall_c = '1;
        flush_c = '1;
        if (go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ex_busy) begin
          stall_c[STG_EX:STG_IF] = '1;
          flush_c[STG_MEM]       = 1'b1;
          state_d                = ST_EX_WAIT;
        end else if (lu_hazard) begin
          stall_c[STG_ID:STG_IF] = '1;
          flush_c[STG_EX]        = 1'b1;
          bub_cnt_d              = BUB_W'(LOAD_LAT - 1);
          if (LOAD_LAT > 1) state_d = ST_LU_STALL;
        end else if (id_halt) begin
          stall_c[STG_IF] = 1'b1;
          flush_c[STG_ID] = 1'b1;
          drain_cnt_d     = DRAIN_W'(NUM_STAGES - 2);
          state_d         = ST_DRAIN;
        end else if (id_branch) begin
          flush_c[STG_ID] = 1'b1;
        end
      end
      ST_LU_STALL: begin
        if (ex_busy) begin
          stall_c[STG_EX:STG_IF] = '1;
          flush_c[STG_MEM]       = 1'b1;
          state_d                = ST_EX_WAIT;
        end else begin
          stall_c[STG_ID:STG_IF] = '1;
          flush_c[STG_EX]        = 1'b1;
          bub_cnt_d              = bub_cnt_q - BUB_W'(1);
          if (bub_cnt_q <= BUB_W'(1)) state_d = ST_RUN;
        end
      end
      ST_EX_WAIT: begin
        stall_c[STG_EX:STG_IF] = '1;
        flush_c[STG_MEM]       = 1'b1;
        if (!ex_busy) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        stall_c[STG_ID:STG_IF] = '1;
        drain_cnt_d            = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_q <= DRAIN_W'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        stall_c = '1;
      end
      default: begin
        stall_c = '1;
        flush_c = '1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bub_cnt_q   <= '0;
      drain_cnt_q <= '0;
      running_q   <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bub_cnt_q   <= bub_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      running_q   <= state_d inside {ST_RUN, ST_LU_STALL, ST_EX_WAIT, ST_DRAIN};
      halt_q      <= (state_d == ST_HALTED);
    end
  end

  assign stall     = stall_c;
  assign flush     = flush_c;
  assign running   = running_q;
  assign halt      = halt_q;
  assign dbg_state = state_q;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .src_addr_i (id_rs1_addr),
    .ex_addr_i  (ex_rd_addr),
    .ex_we_i    (ex_rd_we),
    .mem_addr_i (mem_rd_addr),
    .mem_we_i   (mem_rd_we),
    .wb_addr_i  (wb_rd_addr),
    .wb_we_i    (wb_rd_we),
    .sel_o      (fwd_rs1_sel)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .src_addr_i (id_rs2_addr),
    .ex_addr_i  (ex_rd_addr),
    .ex_we_i    (ex_rd_we),
    .mem_addr_i (mem_rd_addr),
    .mem_we_i   (mem_rd_we),
    .wb_addr_i  (wb_rd_addr),
    .wb_we_i    (wb_rd_we),
    .sel_o      (fwd_rs2_sel)
  );

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic             br_flush;
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  // A branch flush only happens in RUN when nothing of higher priority fired.
  assign br_flush = (state_q == ST_RUN) && !ex_busy && !lu_hazard &&
                    !id_halt && id_branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_c[STG_ID] && running_q && !(&perf_stall_q)) begin
        perf_stall_q <= perf_stall_q + CNT_W'(1);
      end
      if (br_flush && !(&perf_flush_q)) begin
        perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  import core_pkg::*;

  localparam int AW  = 5;
  localparam int NS  = 5;
  localparam int LAT = 2;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_BUBBLE = 2;
  localparam int M_EXWAIT = 3;
  localparam int M_DRAIN  = 4;
  localparam int M_HALTED = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic [AW-1:0] id_rs1_addr = '0, id_rs2_addr = '0;
  logic          id_rs1_re = 1'b0, id_rs2_re = 1'b0;
  logic          id_branch = 1'b0, id_halt = 1'b0;
  logic [AW-1:0] ex_rd_addr = '0, mem_rd_addr = '0, wb_rd_addr = '0;
  logic          ex_rd_we = 1'b0, ex_is_load = 1'b0;
  logic          mem_rd_we = 1'b0, wb_rd_we = 1'b0;
  logic          ex_busy = 1'b0;

  logic [NS-1:0] stall, flush;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
  logic          running, halt;
  state_t        dbg_state;

  int total = 0;
  int bad = 0;
  int m_mode = M_IDLE;
  int m_left = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .NUM_STAGES(NS), .LOAD_LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .id_rs1_addr (id_rs1_addr),
    .id_rs1_re   (id_rs1_re),
    .id_rs2_addr (id_rs2_addr),
    .id_rs2_re   (id_rs2_re),
    .id_branch   (id_branch),
    .id_halt     (id_halt),
    .ex_rd_addr  (ex_rd_addr),
    .ex_rd_we    (ex_rd_we),
    .ex_is_load  (ex_is_load),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_we   (mem_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_we    (wb_rd_we),
    .ex_busy     (ex_busy),
    .stall       (stall),
    .flush       (flush),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .running     (running),
    .halt        (halt),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [NS-1:0] ones_below(input int n);
    return NS'((1 << n) - 1);
  endfunction

  function automatic logic [NS-1:0] bit_at(input int n);
    return NS'(1 << n);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [AW-1:0] src);
    logic [AW-1:0] pa [3];
    logic          pw [3];
    pa = '{ex_rd_addr, mem_rd_addr, wb_rd_addr};
    pw = '{ex_rd_we, mem_rd_we, wb_rd_we};
    if (src == '0) return 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (pw[k] && pa[k] == src) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic load_use();
    return ex_is_load && ex_rd_we && (ex_rd_addr != '0) &&
           ((id_rs1_re && id_rs1_addr == ex_rd_addr) ||
            (id_rs2_re && id_rs2_addr == ex_rd_addr));
  endfunction

  task automatic expected(output logic [NS-1:0] st, output logic [NS-1:0] fl);
    st = '0;
    fl = '0;
    if (m_mode == M_IDLE) begin
      st = ones_below(NS); fl = ones_below(NS);
    end else if (m_mode == M_HALTED) begin
      st = ones_below(NS);
    end else if (m_mode == M_EXWAIT) begin
      st = ones_below(3); fl = bit_at(3);
    end else if (m_mode == M_DRAIN) begin
      st = ones_below(2);
    end else if (ex_busy) begin
      st = ones_below(3); fl = bit_at(3);
    end else if (m_mode == M_BUBBLE || load_use()) begin
      st = ones_below(2); fl = bit_at(2);
    end else if (id_halt) begin
      st = bit_at(0); fl = bit_at(1);
    end else if (id_branch) begin
      fl = bit_at(1);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_left = 0;
    end else begin
      if (m_mode == M_IDLE) begin
        if (go) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (ex_busy) m_mode = M_EXWAIT;
        else if (load_use()) begin
          if (LAT > 1) begin
            m_mode = M_BUBBLE;
            m_left = LAT - 1;
          end
        end else if (id_halt) begin
          m_mode = M_DRAIN;
          m_left = NS - 2;
        end
      end else if (m_mode == M_BUBBLE) begin
        if (ex_busy) m_mode = M_EXWAIT;
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_RUN;
        end
      end else if (m_mode == M_EXWAIT) begin
        if (!ex_busy) m_mode = M_RUN;
      end else if (m_mode == M_DRAIN) begin
        m_left--;
        if (m_left == 0) m_mode = M_HALTED;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp_blk
    logic [NS-1:0] es, ef;
    logic          er;
    expected(es, ef);
    er = (m_mode == M_RUN) || (m_mode == M_BUBBLE) || (m_mode == M_EXWAIT) || (m_mode == M_DRAIN);
    check("m_stall", 32'(stall), 32'(es));
    check("m_flush", 32'(flush), 32'(ef));
    check("m_fwd1", 32'(fwd_rs1_sel), 32'(fwd_pick(id_rs1_addr)));
    check("m_fwd2", 32'(fwd_rs2_sel), 32'(fwd_pick(id_rs2_addr)));
    check("m_running", 32'(running), 32'(er));
    check("m_halt", 32'(halt), 32'(m_mode == M_HALTED));
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_re = 1'b0; id_rs2_re = 1'b0;
    id_branch = 1'b0; id_halt = 1'b0;
    ex_rd_addr = '0; ex_rd_we = 1'b0; ex_is_load = 1'b0;
    mem_rd_addr = '0; mem_rd_we = 1'b0; wb_rd_addr = '0; wb_rd_we = 1'b0;
    ex_busy = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = AW'(5);
    id_rs1_addr = AW'(5); id_rs1_re = 1'b1;
  endtask

  int halted_cycles = 0;

  initial begin
    clear_inputs();
    next_cycle();
    next_cycle();
    #3;
    check("rst_stall", 32'(stall), 32'h1f);
    check("rst_flush", 32'(flush), 32'h1f);
    check("rst_fwd1", 32'(fwd_rs1_sel), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);

    next_cycle(); reset = 1'b1; go = 1'b1; #3;
    check("idle_stall", 32'(stall), 32'h1f);
    next_cycle(); #3;
    check("run_stall", 32'(stall), 32'h0);
    check("run_flush", 32'(flush), 32'h0);
    check("run_running", 32'(running), 32'h1);

    // load-use with two bubble cycles
    next_cycle(); set_load_use(); #3;
    check("lu1_stall", 32'(stall), 32'h03);
    check("lu1_flush", 32'(flush), 32'h04);
    next_cycle(); ex_is_load = 1'b0; ex_rd_we = 1'b0; #3;
    check("lu2_stall", 32'(stall), 32'h03);
    check("lu2_flush", 32'(flush), 32'h04);
    next_cycle(); clear_inputs(); #3;
    check("lu_exit_stall", 32'(stall), 32'h0);

    // forwarding priority
    next_cycle(); ex_rd_addr = AW'(7); ex_rd_we = 1'b1; mem_rd_addr = AW'(7); mem_rd_we = 1'b1;
    id_rs2_addr = AW'(7); #3;
    check("fwd_ex", 32'(fwd_rs2_sel), 32'h1);
    next_cycle(); ex_rd_addr = '0; mem_rd_addr = '0; id_rs2_addr = '0; #3;
    check("fwd_x0", 32'(fwd_rs2_sel), 32'h0);
    next_cycle(); ex_rd_we = 1'b0; mem_rd_addr = AW'(9); wb_rd_addr = AW'(9); wb_rd_we = 1'b1;
    id_rs2_addr = AW'(9); #3;
    check("fwd_mem", 32'(fwd_rs2_sel), 32'h2);
    next_cycle(); mem_rd_we = 1'b0; #3;
    check("fwd_wb", 32'(fwd_rs2_sel), 32'h3);

    // branch coinciding with load-use is ignored while ID stalls
    next_cycle(); clear_inputs(); set_load_use(); id_branch = 1'b1; #3;
    check("brlu1_flush", 32'(flush), 32'h04);
    next_cycle(); ex_is_load = 1'b0; ex_rd_we = 1'b0; #3;
    check("brlu2_flush", 32'(flush), 32'h04);
    next_cycle(); clear_inputs(); id_branch = 1'b1; #3;
    check("br_flush", 32'(flush), 32'h02);
    check("br_stall", 32'(stall), 32'h0);
    next_cycle(); id_branch = 1'b0; #3;
    check("br_after", 32'(flush), 32'h0);

    // multi-cycle EX
    for (int k = 0; k < 4; k++) begin
      next_cycle(); ex_busy = (k < 3); #3;
      check("busy_stall", 32'(stall), 32'h07);
      check("busy_flush", 32'(flush), 32'h08);
    end
    next_cycle(); #3;
    check("busy_exit", 32'(stall), 32'h0);

    // halt and drain
    next_cycle(); id_halt = 1'b1; #3;
    check("halt_stall", 32'(stall), 32'h01);
    check("halt_flush", 32'(flush), 32'h02);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); id_halt = 1'b0; #3;
      check("drain_stall", 32'(stall), 32'h03);
      check("drain_halt", 32'(halt), 32'h0);
    end
    next_cycle(); #3;
    check("halted_halt", 32'(halt), 32'h1);
    check("halted_stall", 32'(stall), 32'h1f);
    check("halted_flush", 32'(flush), 32'h0);
    check("halted_running", 32'(running), 32'h0);

    // reset in the middle of DRAIN
    next_cycle(); reset = 1'b0;
    next_cycle(); reset = 1'b1;
    next_cycle(); id_halt = 1'b1;
    next_cycle(); id_halt = 1'b0; #1 reset = 1'b0; #2;
    check("mid_rst_stall", 32'(stall), 32'h1f);
    check("mid_rst_flush", 32'(flush), 32'h1f);
    check("mid_rst_running", 32'(running), 32'h0);
    next_cycle(); reset = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (!reset) reset = 1'b1;
      go          = ($urandom_range(0, 3) != 0);
      id_rs1_addr = AW'($urandom_range(0, 3));
      id_rs2_addr = AW'($urandom_range(0, 3));
      id_rs1_re   = 1'($urandom_range(0, 1));
      id_rs2_re   = 1'($urandom_range(0, 1));
      id_branch   = ($urandom_range(0, 3) == 0);
      id_halt     = ($urandom_range(0, 60) == 0);
      ex_rd_addr  = AW'($urandom_range(0, 3));
      ex_rd_we    = 1'($urandom_range(0, 1));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      mem_rd_addr = AW'($urandom_range(0, 3));
      mem_rd_we   = 1'($urandom_range(0, 1));
      wb_rd_addr  = AW'($urandom_range(0, 3));
      wb_rd_we    = 1'($urandom_range(0, 1));
      ex_busy     = ($urandom_range(0, 5) == 0);
      if (m_mode == M_HALTED) halted_cycles++;
      else halted_cycles = 0;
      if (halted_cycles > 3 || $urandom_range(0, 249) == 0) begin
        #1 reset = 1'b0;
        halted_cycles = 0;
      end
    end

    next_cycle(); reset = 1'b1; clear_inputs();
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
